// File: rtl/tpic_chain_check_pkg.sv
// Shared types and constants for the TPIC shift-chain monitor.
package tpic_chain_check_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_COMPARE = 2'd2
    } state_e;

    localparam logic [7:0] FAULT_NONE      = 8'hFF;
    localparam int         TPIC_CHAIN_BITS = 432;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tpic_chain_check_edge_det.sv
// One-flop rising-edge detector; rise_o is combinational from the live input.
module tpic_chain_check_edge_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) d_q <= 1'b0;
        else         d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/tpic_chain_check.sv
// TPIC chain monitor: compares serial readback of frame N with the data latched for frame N-1.
// Result pulse 2+k clks after rck for a bad byte k, 2+NBYTES on pass, 2 on length error; no backpressure.
module tpic_chain_check
    import tpic_chain_check_pkg::*;
#(
    parameter int WIDTH = TPIC_CHAIN_BITS
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             sclk_i,
    input  logic             rck_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             result_valid_o,
    output logic             chain_ok_o,
    output logic [7:0]       fault_byte_o,
    output logic             length_err_o,
    output logic [15:0]      fault_cnt_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int             NBYTES   = WIDTH / 8;
    localparam int             CW       = $clog2(WIDTH + 2);
    localparam int             IW       = $clog2(WIDTH + 8);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [7:0]     K_END    = 8'(NBYTES);

    logic sclk_rise, rck_rise, sin_q;

    tpic_chain_check_edge_det u_sclk_det (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (sclk_i),
        .rise_o (sclk_rise)
    );

    tpic_chain_check_edge_det u_rck_det (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (rck_i),
        .rise_o (rck_rise)
    );

    always_ff @(posedge clk_i) begin
        sin_q <= sin_i;
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cap_q, cap_d, snap_q, snap_d, exp_q, exp_d, chk_q, chk_d;
    logic [CW-1:0]      bitcnt_q, bitcnt_d;
    logic               len_ok_q, len_ok_d;
    logic [7:0]         k_q, k_d;
    logic               res_vld_q, res_vld_d, chain_ok_q, chain_ok_d, len_err_q, len_err_d;
    logic [7:0]         fault_byte_q, fault_byte_d;
    logic [15:0]        fault_cnt_q, fault_cnt_d, frame_cnt_q, frame_cnt_d;

    logic [WIDTH-1:0]   cap_shift;
    logic [CW-1:0]      cnt_inc;
    logic [IW-1:0]      bidx;
    logic [7:0]         snap_byte, chk_byte;
    logic               latch_frame, finish, res_ok, res_lerr;
    logic [7:0]         res_fb;

    // A bit shifted in the same clk as rck still belongs to the closing frame.
    assign cap_shift = sclk_rise ? {cap_q[WIDTH-2:0], sin_q} : cap_q;
    assign cnt_inc   = (sclk_rise && bitcnt_q != CNT_SAT) ? bitcnt_q + 1'b1 : bitcnt_q;
    assign bidx      = IW'({k_q, 3'b000});
    assign snap_byte = snap_q[bidx +: 8];
    assign chk_byte  = chk_q[bidx +: 8];

    always_comb begin
        state_d      = state_q;
        cap_d        = cap_shift;
        bitcnt_d     = cnt_inc;
        snap_d       = snap_q;
        exp_d        = exp_q;
        chk_d        = chk_q;
        len_ok_d     = len_ok_q;
        k_d          = k_q;
        res_vld_d    = 1'b0;
        chain_ok_d   = chain_ok_q;
        fault_byte_d = fault_byte_q;
        len_err_d    = len_err_q;
        fault_cnt_d  = fault_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        latch_frame  = 1'b0;
        finish       = 1'b0;
        res_ok       = 1'b0;
        res_lerr     = 1'b0;
        res_fb       = FAULT_NONE;

        if (!enable_i) begin
            state_d  = ST_UNSYNC;
            cap_d    = '0;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                ST_UNSYNC: begin
                    if (rck_rise) begin
                        exp_d    = data_i;
                        cap_d    = '0;
                        bitcnt_d = '0;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    latch_frame = rck_rise;
                end
                ST_COMPARE: begin
                    if (rck_rise) begin
                        // New frame arrived before the scan ended: report it as a length fault.
                        finish      = 1'b1;
                        res_lerr    = 1'b1;
                        latch_frame = 1'b1;
                    end else if (!len_ok_q) begin
                        finish   = 1'b1;
                        res_lerr = 1'b1;
                        state_d  = ST_SHIFT;
                    end else if (k_q == K_END) begin
                        finish  = 1'b1;
                        res_ok  = 1'b1;
                        state_d = ST_SHIFT;
                    end else if (snap_byte != chk_byte) begin
                        finish  = 1'b1;
                        res_fb  = k_q;
                        state_d = ST_SHIFT;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end

        if (latch_frame) begin
            snap_d   = cap_shift;
            len_ok_d = (cnt_inc == CNT_FULL);
            chk_d    = exp_q;
            exp_d    = data_i;
            cap_d    = '0;
            bitcnt_d = '0;
            k_d      = 8'd0;
            state_d  = ST_COMPARE;
        end

        if (finish) begin
            res_vld_d    = 1'b1;
            chain_ok_d   = res_ok;
            fault_byte_d = res_fb;
            len_err_d    = res_lerr;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            if (!res_ok) fault_cnt_d = sat_inc16(fault_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_UNSYNC;
            cap_q        <= '0;
            bitcnt_q     <= '0;
            snap_q       <= '0;
            exp_q        <= '0;
            chk_q        <= '0;
            len_ok_q     <= 1'b0;
            k_q          <= 8'd0;
            res_vld_q    <= 1'b0;
            chain_ok_q   <= 1'b0;
            fault_byte_q <= FAULT_NONE;
            len_err_q    <= 1'b0;
            fault_cnt_q  <= 16'd0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            bitcnt_q     <= bitcnt_d;
            snap_q       <= snap_d;
            exp_q        <= exp_d;
            chk_q        <= chk_d;
            len_ok_q     <= len_ok_d;
            k_q          <= k_d;
            res_vld_q    <= res_vld_d;
            chain_ok_q   <= chain_ok_d;
            fault_byte_q <= fault_byte_d;
            len_err_q    <= len_err_d;
            fault_cnt_q  <= fault_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign result_valid_o = res_vld_q;
    assign chain_ok_o     = chain_ok_q;
    assign fault_byte_o   = fault_byte_q;
    assign length_err_o   = len_err_q;
    assign fault_cnt_o    = fault_cnt_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_tpic_chain_check.sv
// Bench for tpic_chain_check: frame-level result model checked every clk, plus literal pins per scenario.
module tb_tpic_chain_check;

    logic         clk = 1'b0;
    logic         reset_i, enable_i, sclk_i, rck_i, sin_i;
    logic [431:0] data_i;
    logic         result_valid_o, chain_ok_o, length_err_o;
    logic [7:0]   fault_byte_o;
    logic [15:0]  fault_cnt_o, frame_cnt_o;

    always #5 clk = ~clk;

    tpic_chain_check dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .sclk_i        (sclk_i),
        .rck_i         (rck_i),
        .sin_i         (sin_i),
        .data_i        (data_i),
        .result_valid_o(result_valid_o),
        .chain_ok_o    (chain_ok_o),
        .fault_byte_o  (fault_byte_o),
        .length_err_o  (length_err_o),
        .fault_cnt_o   (fault_cnt_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        int         due;
        bit         ok;
        logic [7:0] fb;
        bit         lerr;
    } res_t;

    res_t         pend[$];
    bit           bits[$];
    logic [431:0] chain = '0;
    logic [431:0] m_exp = '0;
    bit           m_sync = 0, m_en = 0, chk_en = 0;
    bit           e_ok = 0, e_len = 0;
    logic [7:0]   e_fb = 8'hFF;
    logic [15:0]  e_fcnt = 0, e_frcnt = 0;
    int           rck_cyc = 0, first_rv = -1, rv_cnt = 0;
    bit           f_ok = 0, f_len = 0;
    logic [7:0]   f_fb = 0;

    task automatic model_bit(input bit b);
        if (m_en) bits.push_back(b);
    endtask

    task automatic model_rck(input logic [431:0] d);
        logic [431:0] capv;
        int           bad;
        res_t         r;
        if (m_en && m_sync) begin
            capv = '0;
            foreach (bits[i]) capv = {capv[430:0], bits[i]};
            bad = -1;
            for (int k = 0; k < 54; k++)
                if (bad < 0 && capv[8*k +: 8] != m_exp[8*k +: 8]) bad = k;
            if (pend.size() > 0 && pend[$].due > cyc) begin
                while (pend.size() > 0 && pend[$].due > cyc) void'(pend.pop_back());
                r.due = cyc + 1; r.ok = 0; r.fb = 8'hFF; r.lerr = 1;
                pend.push_back(r);
            end
            r.lerr = 0; r.ok = 0; r.fb = 8'hFF;
            if (bits.size() != 432) begin
                r.due = cyc + 2; r.lerr = 1;
            end else if (bad >= 0) begin
                r.due = cyc + 2 + bad; r.fb = 8'(bad);
            end else begin
                r.due = cyc + 2 + 54; r.ok = 1;
            end
            pend.push_back(r);
        end
        if (m_en) m_sync = 1;
        m_exp = d;
        chain = d;
        bits.delete();
        rck_cyc  = cyc;
        first_rv = -1;
    endtask

    task automatic model_disable();
        m_en = 0;
        m_sync = 0;
        bits.delete();
        while (pend.size() > 0 && pend[$].due > cyc) void'(pend.pop_back());
    endtask

    task automatic model_reset();
        pend.delete();
        bits.delete();
        m_sync = 0;
        e_ok = 0; e_len = 0; e_fb = 8'hFF; e_fcnt = 0; e_frcnt = 0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic exp_rv;
        if (chk_en) begin
            exp_rv = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_rv  = 1'b1;
                e_ok    = pend[0].ok;
                e_fb    = pend[0].fb;
                e_len   = pend[0].lerr;
                e_frcnt = e_frcnt + 16'd1;
                if (!pend[0].ok && e_fcnt != 16'hFFFF) e_fcnt = e_fcnt + 16'd1;
                void'(pend.pop_front());
            end
            chk("result_valid", 32'(result_valid_o), 32'(exp_rv));
            chk("chain_ok", 32'(chain_ok_o), 32'(e_ok));
            chk("fault_byte", 32'(fault_byte_o), 32'(e_fb));
            chk("length_err", 32'(length_err_o), 32'(e_len));
            chk("fault_cnt", 32'(fault_cnt_o), 32'(e_fcnt));
            chk("frame_cnt", 32'(frame_cnt_o), 32'(e_frcnt));
        end
    end

    // Captures the first result after each rck for the literal pins.
    always @(negedge clk) begin
        if (result_valid_o === 1'b1) begin
            rv_cnt++;
            if (first_rv < 0) begin
                first_rv = cyc;
                f_ok  = chain_ok_o;
                f_fb  = fault_byte_o;
                f_len = length_err_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic one_bit(input logic b);
        sin_i  = b;
        sclk_i = 1'b0;
        tick();
        sclk_i = 1'b1;
        model_bit(b);
        tick();
    endtask

    task automatic shift_bits(input int n, input int f0, input int f1);
        for (int i = 0; i < n; i++) begin
            int   idx;
            logic b;
            idx = 431 - i;
            b   = chain[idx];
            if (idx == f0 || idx == f1) b = ~b;
            one_bit(b);
        end
    endtask

    task automatic latch(input logic [431:0] nxt);
        sclk_i = 1'b0;
        data_i = nxt;
        rck_i  = 1'b1;
        model_rck(nxt);
        tick();
        tick();
        rck_i = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && pend.size() > 0; i++) tick();
        chk("model_drained", 32'(pend.size()), 32'd0);
        tick();
    endtask

    function automatic logic [431:0] rnd();
        logic [431:0] v;
        v = '0;
        for (int i = 0; i < 14; i++) v = {v[399:0], 32'($urandom)};
        return v;
    endfunction

    logic [431:0] pat_a, pat_b, nxt;
    int           snap_rv;
    logic [15:0]  snap_fr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pat_a = {54{8'h55}};
        pat_b = {54{8'hAA}};
        reset_i = 1'b1; enable_i = 1'b0; sclk_i = 1'b0; rck_i = 1'b0; sin_i = 1'b0; data_i = '0;

        // 1: reset with random inputs
        tick();
        model_reset();
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            enable_i = 1'($urandom); sclk_i = 1'($urandom); rck_i = 1'($urandom);
            sin_i = 1'($urandom); data_i = rnd();
            tick();
        end
        sclk_i = 1'b0; rck_i = 1'b0; sin_i = 1'b0; data_i = '0;
        tick();
        chk("t1_fault_byte", 32'(fault_byte_o), 32'h0FF);
        chk("t1_frame_cnt", 32'(frame_cnt_o), 32'd0);
        chk("t1_fault_cnt", 32'(fault_cnt_o), 32'd0);
        chk("t1_rv_seen", 32'(rv_cnt), 32'd0);
        reset_i = 1'b0; enable_i = 1'b1; m_en = 1;
        tick();

        // 2: loopback pass, A then B
        latch(pat_a);
        shift_bits(432, -1, -1);
        latch(pat_b);
        wait_idle();
        chk("t2_latency", 32'(first_rv - rck_cyc), 32'd56);
        chk("t2_chain_ok", 32'(f_ok), 32'd1);
        chk("t2_fault_byte", 32'(f_fb), 32'h0FF);
        chk("t2_frame_cnt", 32'(frame_cnt_o), 32'd1);

        // 3: bit 3 of byte 5 flipped
        nxt = rnd();
        shift_bits(432, 43, -1);
        latch(nxt);
        wait_idle();
        chk("t3_latency", 32'(first_rv - rck_cyc), 32'd7);
        chk("t3_chain_ok", 32'(f_ok), 32'd0);
        chk("t3_fault_byte", 32'(f_fb), 32'd5);
        chk("t3_fault_cnt", 32'(fault_cnt_o), 32'd1);

        // 3b: two bad bytes, lowest index reported
        nxt = rnd();
        shift_bits(432, 320, 103);
        latch(nxt);
        wait_idle();
        chk("t3b_latency", 32'(first_rv - rck_cyc), 32'd14);
        chk("t3b_fault_byte", 32'(f_fb), 32'd12);
        chk("t3b_fault_cnt", 32'(fault_cnt_o), 32'd2);

        // 4: 431-bit frame, then a full frame whose last bit shares the rck clk
        nxt = rnd();
        shift_bits(431, -1, -1);
        latch(nxt);
        wait_idle();
        chk("t4_latency", 32'(first_rv - rck_cyc), 32'd2);
        chk("t4_length_err", 32'(f_len), 32'd1);
        chk("t4_chain_ok", 32'(f_ok), 32'd0);
        chk("t4_fault_byte", 32'(f_fb), 32'h0FF);
        nxt = rnd();
        shift_bits(431, -1, -1);
        sin_i = chain[0]; sclk_i = 1'b0;
        tick();
        sclk_i = 1'b1;
        model_bit(chain[0]);
        data_i = nxt; rck_i = 1'b1;
        model_rck(nxt);
        tick();
        tick();
        sclk_i = 1'b0; rck_i = 1'b0;
        tick();
        wait_idle();
        chk("t4b_length_err", 32'(f_len), 32'd0);
        chk("t4b_chain_ok", 32'(f_ok), 32'd1);
        chk("t4b_latency", 32'(first_rv - rck_cyc), 32'd56);

        // 5: enable dropped mid-frame
        snap_fr = frame_cnt_o;
        snap_rv = rv_cnt;
        shift_bits(100, -1, -1);
        enable_i = 1'b0;
        model_disable();
        shift_bits(50, -1, -1);
        latch(rnd());
        enable_i = 1'b1; m_en = 1;
        tick();
        shift_bits(432, -1, -1);
        latch(rnd());
        for (int i = 0; i < 70; i++) tick();
        chk("t5_no_pulse", 32'(rv_cnt - snap_rv), 32'd0);
        chk("t5_frame_hold", 32'(frame_cnt_o), 32'(snap_fr));
        shift_bits(432, -1, -1);
        latch(rnd());
        wait_idle();
        chk("t5_chain_ok", 32'(f_ok), 32'd1);
        chk("t5_frame_cnt", 32'(frame_cnt_o), 32'(snap_fr + 16'd1));

        // 6: rck 10 clks into the scan
        shift_bits(432, -1, -1);
        latch(rnd());
        for (int i = 0; i < 8; i++) tick();
        latch(rnd());
        wait_idle();
        chk("t6_abort_latency", 32'(first_rv - rck_cyc), 32'd1);
        chk("t6_abort_len", 32'(f_len), 32'd1);
        chk("t6_abort_ok", 32'(f_ok), 32'd0);
        shift_bits(432, -1, -1);
        latch(rnd());
        wait_idle();
        chk("t6_next_ok", 32'(f_ok), 32'd1);

        // 6b: reset in the middle of a scan
        shift_bits(432, -1, -1);
        latch(rnd());
        for (int i = 0; i < 10; i++) tick();
        snap_rv = rv_cnt;
        reset_i = 1'b1;
        tick();
        model_reset();
        tick();
        chk("t6b_frame_cnt", 32'(frame_cnt_o), 32'd0);
        chk("t6b_fault_byte", 32'(fault_byte_o), 32'h0FF);
        reset_i = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        chk("t6b_no_pulse", 32'(rv_cnt - snap_rv), 32'd0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
